event_supervisor: RTL
=====================

EVENT_SUPERVISOR -- requirements
Module: event_supervisor

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, event-counter width (>=2).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, number of IDLE cycles without an event that constitute one miss (>=2).
REQ-003 The block SHALL have parameter MAX_MISS, default 3, number of consecutive misses that force ERROR (>=1).
REQ-004 The block SHALL have parameter SATURATE, default 1; 1 = count saturates at all-ones, 0 = count wraps to 0.
REQ-005 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have port evt  input  1  event request (M), sampled each cycle, level treated per cycle.
REQ-008 The block SHALL have port clr_err  input  1  clears ERROR, sampled only in ERROR.
REQ-009 The block SHALL have port count  output  CNT_W  accepted-event count.
REQ-010 The block SHALL have port miss_cnt  output  $clog2(MAX_MISS+1)  consecutive-miss count.
REQ-011 The block SHALL have port en_cont  output  1  high for exactly the cycle an event is accepted.
REQ-012 The block SHALL have port error  output  1  high while in ERROR.
REQ-013 The block SHALL have port rst_timer  output  1  high whenever the internal idle timer is being cleared.
REQ-014 The block SHALL have port state_o  output  2  current state encoding.

Function
REQ-015 States SHALL be IDLE=2'b00, COUNT=2'b01, WAIT=2'b10, ERROR=2'b11; unused encodings do not exist (2 bits, all used).
REQ-016 en_cont, error, rst_timer, state_o SHALL be Moore outputs decoded from the state register only.
REQ-017 IDLE: internal timer (width $clog2(TIMEOUT)) SHALL increment by 1 per cycle starting from 0.
REQ-018 IDLE with evt=1 SHALL go to COUNT next cycle, regardless of timer value (evt beats timeout).
REQ-019 IDLE with evt=0 and timer==TIMEOUT-1 SHALL go to WAIT; otherwise stay in IDLE.
REQ-020 COUNT SHALL last one cycle: en_cont=1, rst_timer=1, count += 1 (saturate or wrap per SATURATE), miss_cnt := 0, timer := 0, next state IDLE.
REQ-021 WAIT SHALL last one cycle with rst_timer=1, timer := 0.
REQ-022 WAIT with evt=1 SHALL go to COUNT without incrementing miss_cnt.
REQ-023 WAIT with evt=0 SHALL increment miss_cnt and go to ERROR if miss_cnt==MAX_MISS-1, else IDLE.
REQ-024 ERROR SHALL assert error=1 and rst_timer=1, freeze count and miss_cnt, ignore evt.
REQ-025 ERROR with clr_err=1 SHALL go to IDLE next cycle with miss_cnt := 0, timer := 0, count retained.
REQ-026 clr_err outside ERROR SHALL have no effect.
REQ-027 With no events, ERROR SHALL be entered exactly MAX_MISS*(TIMEOUT+1) cycles after leaving reset or clr_err.

Reset
REQ-028 rst=1 SHALL immediately (asynchronously) force state IDLE, count=0, miss_cnt=0, timer=0, en_cont=0, error=0, rst_timer=0, state_o=2'b00.
REQ-029 rst asserted in any state, including mid-COUNT, SHALL discard the pending increment; rst release SHALL restart from IDLE with timer=0.

Verification (CNT_W=4, TIMEOUT=4, MAX_MISS=3)
REQ-030 Reset, evt=1 for one cycle at cycle 2 -> en_cont=1 for one cycle, count=1, miss_cnt=0, state returns to 2'b00.
REQ-031 20 evt pulses spaced 2 cycles apart: SATURATE=1 -> count ends 15; SATURATE=0 -> count ends 4 (wrap after 15).
REQ-032 evt held 0 after reset -> WAIT at cycles 4, 9, 14; miss_cnt 1, 2; ERROR entered at cycle 15, error=1, rst_timer=1.
REQ-033 In ERROR, evt pulses -> count and miss_cnt unchanged; clr_err=1 -> next cycle IDLE, error=0, miss_cnt=0, count retained.
REQ-034 evt=1 exactly on timer==3 cycle -> COUNT, miss_cnt unchanged; evt=1 while in WAIT -> COUNT, miss_cnt not incremented.
REQ-035 rst pulsed asynchronously mid-COUNT with count=7 -> count=0, en_cont=0 before next clk edge; state_o=2'b00.

Source files
------------

// File: rtl/event_supervisor.sv
// Event supervisor: counts accepted events and flags ERROR after MAX_MISS consecutive idle
// timeouts. Moore outputs are decoded from the state register.
module event_supervisor #(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned MAX_MISS = 3,
   parameter bit          SATURATE = 1'b1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              evt,
   input  logic                              clr_err,
   output logic [CNT_W-1:0]                  count,
   output logic [$clog2(MAX_MISS+1)-1:0]     miss_cnt,
   output logic                              en_cont,
   output logic                              error,
   output logic                              rst_timer,
   output logic [1:0]                        state_o
);

   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam int unsigned MW = $clog2(MAX_MISS + 1);
   localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
   localparam logic [MW-1:0] MissLast  = MW'(MAX_MISS - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StCount = 2'b01,
      StWait  = 2'b10,
      StError = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [MW-1:0]    miss_q, miss_d;
   logic [TW-1:0]    timer_q, timer_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         count_q <= '0;
         miss_q  <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         miss_q  <= miss_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      miss_d  = miss_q;
      timer_d = timer_q;
      unique case (state_q)
         StIdle: begin
            timer_d = timer_q + 1'b1;
            // An event wins over a timeout landing on the same cycle.
            if (evt) begin
               state_d = StCount;
            end else if (timer_q == TimerLast) begin
               state_d = StWait;
            end
         end
         StCount: begin
            if (!(SATURATE && (count_q == '1))) begin
               count_d = count_q + 1'b1;
            end
            miss_d  = '0;
            timer_d = '0;
            state_d = StIdle;
         end
         StWait: begin
            timer_d = '0;
            if (evt) begin
               state_d = StCount;
            end else begin
               miss_d  = miss_q + 1'b1;
               state_d = (miss_q == MissLast) ? StError : StIdle;
            end
         end
         StError: begin
            if (clr_err) begin
               state_d = StIdle;
               miss_d  = '0;
               timer_d = '0;
            end
         end
      endcase
   end

   always_comb begin
      en_cont   = (state_q == StCount);
      error     = (state_q == StError);
      rst_timer = (state_q != StIdle);
      state_o   = state_q;
   end

   assign count    = count_q;
   assign miss_cnt = miss_q;

endmodule
